// File: rtl/cart_loader.sv
// Cartridge download front end: streams bytes into the ROM buffer, measures the image,
// decodes the bank-switch scheme from the file extension and decides SuperChip enable.
module cart_loader #(
  parameter int unsigned ROM_AW      = 15,
  parameter int unsigned SC_MIN_SIZE = 8192
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [31:0]       ioctl_file_ext,
  input  logic [1:0]        sc_mode,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_wa,
  output logic [7:0]        rom_wd,
  output logic [16:0]       rom_size,
  output logic [3:0]        force_bs,
  output logic              sc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, FINAL} state_t;

  state_t      state, state_n;
  logic        dl_q;
  logic        armed;
  logic [23:0] ext;
  logic        s_tag;
  logic        sc_ok;
  logic        first_wr;
  logic [24:0] prev_addr;
  logic [7:0]  ref_byte;

  logic        rise, fall, accept, in_rom;
  logic [25:0] addr_p1;
  logic [16:0] size_cand;
  logic [3:0]  bs_dec;
  logic        sc_dec;

  // armed stays low after reset until download is seen low, so a stream already
  // in progress at reset release cannot start a load.
  assign rise    = ioctl_download & ~dl_q & armed;
  assign fall    = ~ioctl_download & dl_q;
  assign accept  = (state == LOAD) && ioctl_wr && !rise;
  assign in_rom  = (ioctl_addr[24:ROM_AW] == '0);
  assign addr_p1 = {1'b0, ioctl_addr} + 26'd1;
  assign size_cand = (|addr_p1[25:17]) ? '1 : addr_p1[16:0];

  assign busy = (state == LOAD) || (state == FINAL);
  assign done = (state == FINAL);

  always_comb begin
    state_n = state;
    if (rise) begin
      state_n = LOAD;
    end else begin
      case (state)
        IDLE:    state_n = IDLE;
        LOAD:    if (fall) state_n = FINAL;
        FINAL:   state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    bs_dec = '0;
    case (ext)
      ".F8":   bs_dec = 4'd1;
      ".F6":   bs_dec = 4'd2;
      ".FE":   bs_dec = 4'd3;
      ".E0":   bs_dec = 4'd4;
      ".3F":   bs_dec = 4'd5;
      ".F4":   bs_dec = 4'd6;
      ".P2":   bs_dec = 4'd7;
      ".FA":   bs_dec = 4'd8;
      ".CV":   bs_dec = 4'd9;
      default: bs_dec = '0;
    endcase
  end

  always_comb begin
    sc_dec = 1'b0;
    case (sc_mode)
      2'd0:    sc_dec = s_tag | (sc_ok & (rom_size >= 17'(SC_MIN_SIZE)));
      2'd1:    sc_dec = 1'b0;
      default: sc_dec = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dl_q      <= 1'b0;
      armed     <= 1'b0;
      ext       <= '0;
      s_tag     <= 1'b0;
      sc_ok     <= 1'b0;
      first_wr  <= 1'b0;
      prev_addr <= '0;
      ref_byte  <= '0;
      rom_we    <= 1'b0;
      rom_wa    <= '0;
      rom_wd    <= '0;
      rom_size  <= '0;
      force_bs  <= '0;
      sc        <= 1'b0;
    end else begin
      state  <= state_n;
      dl_q   <= ioctl_download;
      armed  <= armed | ~ioctl_download;
      rom_we <= accept && in_rom;
      if (accept) begin
        rom_wa <= ioctl_addr[ROM_AW-1:0];
        rom_wd <= ioctl_dout;
      end

      if (rise) begin
        rom_size  <= '0;
        force_bs  <= '0;
        sc        <= 1'b0;
        sc_ok     <= 1'b1;
        first_wr  <= 1'b1;
        prev_addr <= '0;
        ref_byte  <= '0;
        ext       <= (ioctl_file_ext[23:16] == ".") ? ioctl_file_ext[23:0] : ioctl_file_ext[31:8];
        s_tag     <= (ioctl_file_ext[7:0] == "S");
      end else if (accept) begin
        if (size_cand > rom_size) rom_size <= size_cand;
        first_wr  <= 1'b0;
        prev_addr <= ioctl_addr;
        if (!first_wr && (ioctl_addr != prev_addr + 25'd1)) sc_ok <= 1'b0;
        // First 256 bytes of every 4 KB bank must repeat the bank's first byte.
        if (ioctl_addr[11:0] == 12'h000) begin
          ref_byte <= ioctl_dout;
        end else if ((ioctl_addr[11:8] == 4'h0) && (ioctl_dout != ref_byte)) begin
          sc_ok <= 1'b0;
        end
      end else if (state == FINAL) begin
        force_bs <= bs_dec;
        sc       <= sc_dec;
      end
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// Scoreboard bench for cart_loader: stimulus queues expected ROM writes and final
// results; independent monitors compare them as the DUT presents rom_we and done.
module tb_cart_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [31:0] ioctl_file_ext = '0;
  logic [1:0]  sc_mode = '0;
  logic        rom_we;
  logic [14:0] rom_wa;
  logic [7:0]  rom_wd;
  logic [16:0] rom_size;
  logic [3:0]  force_bs;
  logic        sc;
  logic        busy;
  logic        done;

  cart_loader #(.ROM_AW(15), .SC_MIN_SIZE(8192)) dut (
    .clk(clk), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_file_ext(ioctl_file_ext),
    .sc_mode(sc_mode), .rom_we(rom_we), .rom_wa(rom_wa), .rom_wd(rom_wd),
    .rom_size(rom_size), .force_bs(force_bs), .sc(sc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [14:0] a; logic [7:0] d; int stamp; } wexp_t;
  typedef struct { logic [16:0] size; logic [3:0] bs; logic sc; } dexp_t;

  wexp_t wq[$];
  dexp_t dq[$];
  int    tests = 0;
  int    failed = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Write monitor: every rom_we must match the oldest expected write, one cycle late.
  always @(negedge clk) begin
    if (reset_n && rom_we) begin
      if (wq.size() == 0) begin
        check("unexpected_rom_we", {17'd0, rom_wa}, 32'hFFFF_FFFF);
      end else begin
        wexp_t e;
        e = wq.pop_front();
        check("rom_wa", {17'd0, rom_wa}, {17'd0, e.a});
        check("rom_wd", {24'd0, rom_wd}, {24'd0, e.d});
        check("rom_we_latency", cyc, e.stamp);
      end
    end
  end

  // Completion monitor: rom_size during done, force_bs/sc on the following cycle.
  always @(negedge clk) begin
    if (reset_n && done) begin
      if (dq.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        dexp_t e;
        e = dq.pop_front();
        check("rom_size", {15'd0, rom_size}, {15'd0, e.size});
        check("busy_final", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("force_bs", {28'd0, force_bs}, {28'd0, e.bs});
        check("sc", {31'd0, sc}, {31'd0, e.sc});
        check("done_one_cycle", {31'd0, done}, 32'd0);
      end
    end
  end

  function automatic logic [7:0] pat(input logic [24:0] a);
    return (a[11:8] == 4'h0) ? 8'hFF : (a[7:0] ^ 8'h5A);
  endfunction

  task automatic start_dl(input logic [31:0] ext, input logic [1:0] mode, input bit push,
                          input logic [16:0] esize, input logic [3:0] ebs, input logic esc);
    dexp_t e;
    if (push) begin
      e.size = esize; e.bs = ebs; e.sc = esc;
      dq.push_back(e);
    end
    ioctl_file_ext = ext;
    sc_mode = mode;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    check("busy_load", {31'd0, busy}, 32'd1);
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit last);
    wexp_t e;
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (last) ioctl_download = 1'b0;
    if (a < 25'd32768) begin
      e.a = a[14:0]; e.d = d; e.stamp = cyc + 1;
      wq.push_back(e);
    end
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic stream(input int size, input logic [24:0] patch_a, input logic [7:0] patch_v);
    for (int i = 0; i < size; i++) begin
      logic [24:0] a;
      a = 25'(i);
      wr_byte(a, (a == patch_a) ? patch_v : pat(a), i == size - 1);
    end
  endtask

  task automatic finish_dl();
    repeat (4) @(posedge clk);
    #1;
    check("writes_drained", wq.size(), 32'd0);
    check("done_seen", dq.size(), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_rom_we", {31'd0, rom_we}, 32'd0);
    check("rst_rom_size", {15'd0, rom_size}, 32'd0);
    check("rst_force_bs", {28'd0, force_bs}, 32'd0);
    check("rst_sc", {31'd0, sc}, 32'd0);
    check("rst_busy_done", {30'd0, busy, done}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 8 KB uniform regions, .F8, auto SuperChip
    start_dl({8'h00, ".F8"}, 2'd0, 1, 17'd8192, 4'd1, 1'b1);
    stream(8192, '1, 8'h00);
    finish_dl();

    // same image with one region byte disturbed in bank 1
    start_dl({8'h00, ".F8"}, 2'd0, 1, 17'd8192, 4'd1, 1'b0);
    stream(8192, 25'h1042, 8'h00);
    finish_dl();

    // 4 KB .BIN: below SuperChip size threshold, unknown extension
    start_dl(".BIN", 2'd0, 1, 17'd4096, 4'd0, 1'b0);
    stream(4096, '1, 8'h00);
    finish_dl();

    // 40000 bytes: writes past 32 KB dropped but still sized
    start_dl({8'h00, ".F4"}, 2'd1, 1, 17'd40000, 4'd6, 1'b0);
    stream(40000, '1, 8'h00);
    finish_dl();

    // non-sequential jump kills auto-detect even at 8 KB size
    start_dl({8'h00, ".E0"}, 2'd0, 1, 17'd8192, 4'd4, 1'b0);
    for (int i = 0; i < 256; i++) wr_byte(25'(i), 8'hFF, 1'b0);
    wr_byte(25'h1FFF, 8'hFF, 1'b1);
    finish_dl();

    // huge address saturates rom_size, no ROM write
    start_dl({8'h00, ".FA"}, 2'd0, 1, 17'h1FFFF, 4'd8, 1'b0);
    for (int i = 0; i < 4; i++) wr_byte(25'(i), 8'hFF, 1'b0);
    wr_byte(25'h1FFFFFF, 8'h12, 1'b1);
    finish_dl();

    // no-dot extension " F6S": not in table, S tag forces SuperChip in auto mode
    start_dl(" F6S", 2'd0, 1, 17'd16, 4'd0, 1'b1);
    stream(16, '1, 8'h00);
    finish_dl();
    start_dl(" F6S", 2'd1, 1, 17'd16, 4'd0, 1'b0);
    stream(16, '1, 8'h00);
    finish_dl();

    // mode 3 behaves as enable
    start_dl({8'h00, ".CV"}, 2'd3, 1, 17'd16, 4'd9, 1'b1);
    stream(16, '1, 8'h00);
    finish_dl();

    // reset in the middle of a download
    start_dl({8'h00, ".F8"}, 2'd0, 0, 17'd0, 4'd0, 1'b0);
    for (int i = 0; i < 1000; i++) wr_byte(25'(i), pat(25'(i)), 1'b0);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_rom_we", {31'd0, rom_we}, 32'd0);
    check("midrst_rom_size", {15'd0, rom_size}, 32'd0);
    check("midrst_force_bs", {28'd0, force_bs}, 32'd0);
    check("midrst_sc", {31'd0, sc}, 32'd0);
    check("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(1000 + i);
      ioctl_dout = 8'hA5;
      @(posedge clk); #1;
    end
    ioctl_wr = 1'b0;
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_rom_size", {15'd0, rom_size}, 32'd0);
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // fresh load after reset recovery
    start_dl({8'h00, ".F6"}, 2'd2, 1, 17'd16, 4'd2, 1'b1);
    stream(16, '1, 8'h00);
    finish_dl();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
